// File: rtl/inv_loopback_tester.sv
// Tester for a single-pin inverter cell: drives an LFSR bit stream out, checks the
// returned bits against the inverse of what was sent after LAT cycles, and counts errors.
module inv_loopback_tester #(
    parameter int         NUM_VEC = 256,
    parameter int         LAT     = 2,
    parameter int         CNT_W   = 16,
    parameter logic [7:0] SEED    = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             stim_o,
    input  logic             resp_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] vec_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_q;
    logic [7:0]         lfsr_q;
    logic [CNT_W-1:0]   idx_q;
    logic [3:0]         drain_q;
    logic               stim_q;
    logic               stim_vld_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [CNT_W-1:0]   err_q;
    logic [CNT_W-1:0]   vec_q;
    logic [LAT-1:0]     pipe_bit_q;
    logic [LAT-1:0]     pipe_vld_q;

    logic               tail_vld;
    logic               mismatch;
    logic [CNT_W-1:0]   err_d;
    logic [CNT_W-1:0]   vec_d;

    // x^8+x^6+x^5+x^4+1, shifting toward bit 0; new bit enters at bit 7.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[4], s[7:1]};
    endfunction

    // Expect pipe: stage 0 captures the bit currently on stim_o, so the tail
    // holds the vector driven exactly LAT cycles ago.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_bit_q[0] <= 1'b0;
            pipe_vld_q[0] <= 1'b0;
        end else begin
            pipe_bit_q[0] <= stim_q;
            pipe_vld_q[0] <= stim_vld_q;
        end
    end

    generate
        for (genvar gi = 1; gi < LAT; gi++) begin : g_pipe
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe_bit_q[gi] <= 1'b0;
                    pipe_vld_q[gi] <= 1'b0;
                end else begin
                    pipe_bit_q[gi] <= pipe_bit_q[gi-1];
                    pipe_vld_q[gi] <= pipe_vld_q[gi-1];
                end
            end
        end
    endgenerate

    always_comb begin
        tail_vld = pipe_vld_q[LAT-1];
        mismatch = tail_vld && (resp_i == pipe_bit_q[LAT-1]);
        err_d    = (mismatch && (err_q != {CNT_W{1'b1}})) ? err_q + CNT_W'(1) : err_q;
        vec_d    = tail_vld ? vec_q + CNT_W'(1) : vec_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED;
            idx_q      <= '0;
            drain_q    <= '0;
            stim_q     <= 1'b0;
            stim_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            vec_q      <= '0;
        end else begin
            err_q <= err_d;
            vec_q <= vec_d;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        // Vector 0 is SEED[0]; the LFSR is already one step ahead.
                        state_q    <= RUN;
                        lfsr_q     <= lfsr_step(SEED);
                        stim_q     <= SEED[0];
                        stim_vld_q <= 1'b1;
                        idx_q      <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        err_q      <= '0;
                        vec_q      <= '0;
                    end
                end
                RUN: begin
                    lfsr_q <= lfsr_step(lfsr_q);
                    if (idx_q == CNT_W'(NUM_VEC - 1)) begin
                        state_q    <= DRAIN;
                        stim_q     <= 1'b0;
                        stim_vld_q <= 1'b0;
                        drain_q    <= '0;
                    end else begin
                        stim_q <= lfsr_q[0];
                        idx_q  <= idx_q + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_q == 4'(LAT - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                    end else begin
                        drain_q <= drain_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stim_o    = stim_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign vec_count = vec_q;

endmodule

// File: tb/tb_inv_loopback_tester.sv
// Directed bench: LAT=2 cell models (inverter, buffer, single-fault) around the tester,
// plus a CNT_W=4 instance for the saturation corner.
module tb_inv_loopback_tester;

    localparam int         NV   = 256;
    localparam int         LATC = 2;
    localparam logic [7:0] SD   = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stim_o, resp_i, busy, done, pass;
    logic [15:0] err_count, vec_count;

    logic        start_s = 1'b0;
    logic        stim_s, resp_s, busy_s, done_s, pass_s;
    logic [3:0]  err_s, vec_s;

    logic        d1 = 1'b0, d2 = 1'b0, s1 = 1'b0, s2 = 1'b0;
    logic        buf_sel = 1'b0;
    logic        flip = 1'b0;

    int          tests = 0;
    int          fails = 0;
    bit          exp_q[$];

    always #5 clk = ~clk;

    // Cell models: two-cycle round trip from stim to the sample point.
    always @(posedge clk) begin
        d1 <= stim_o;
        d2 <= d1;
        s1 <= stim_s;
        s2 <= s1;
    end
    assign resp_i = (buf_sel ? d2 : ~d2) ^ flip;
    assign resp_s = s2;

    inv_loopback_tester #(.NUM_VEC(NV), .LAT(LATC), .CNT_W(16), .SEED(SD)) dut (
        .clk(clk), .rst(rst), .start(start), .stim_o(stim_o), .resp_i(resp_i),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .vec_count(vec_count)
    );

    inv_loopback_tester #(.NUM_VEC(15), .LAT(2), .CNT_W(4), .SEED(SD)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .stim_o(stim_s), .resp_i(resp_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s), .vec_count(vec_s)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic push_seq();
        logic [7:0] s;
        s = SD;
        exp_q.delete();
        for (int k = 0; k < NV; k++) begin
            exp_q.push_back(s[0]);
            s = {s[0] ^ s[2] ^ s[3] ^ s[4], s[7:1]};
        end
    endtask

    // One full run; bad >= 0 corrupts the response to that vector only.
    task automatic run_big(input string tag, input bit buf_mode, input int bad,
                           input bit mid_start, input int exp_err);
        int  n;
        bit  e;
        buf_sel = buf_mode;
        push_seq();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        check({tag, "_pass_drop"}, {31'd0, pass}, 32'd0);
        n = 0;
        while (busy && n < 2000) begin
            flip  = ((n - LATC) == bad);
            start = (mid_start && n == 50);
            if (n < NV) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
                check({tag, "_stim"}, {31'd0, stim_o}, {31'd0, e});
            end else begin
                check({tag, "_stim_drain"}, {31'd0, stim_o}, 32'd0);
            end
            @(negedge clk);
            n++;
        end
        flip  = 1'b0;
        start = 1'b0;
        check({tag, "_busy_cycles"}, n, NV + LATC);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_pass"}, {31'd0, pass}, {31'd0, exp_err == 0});
        check({tag, "_err"}, {16'd0, err_count}, exp_err);
        check({tag, "_vec"}, {16'd0, vec_count}, NV);
        $display("[TB] run %s: busy %0d cycles, err=%0d vec=%0d pass=%0b",
                 tag, n, err_count, vec_count, pass);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_stim", {31'd0, stim_o}, 32'd0);
        check("rst_err", {16'd0, err_count}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_big("inv", 1'b0, -1, 1'b0, 0);
        run_big("buf", 1'b1, -1, 1'b0, NV);
        run_big("fault10", 1'b0, 10, 1'b0, 1);
        run_big("midstart", 1'b0, -1, 1'b1, 0);

        // Abort at vector 100 with an asynchronous reset.
        buf_sel = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (100) @(negedge clk);
        check("abort_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_stim", {31'd0, stim_o}, 32'd0);
        @(posedge clk); #1;
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_pass", {31'd0, pass}, 32'd0);
        check("abort_err", {16'd0, err_count}, 32'd0);
        check("abort_vec", {16'd0, vec_count}, 32'd0);
        $display("[TB] run abort: reset at vector 100, outputs cleared");
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        run_big("fresh", 1'b0, -1, 1'b0, 0);
        run_big("b2b", 1'b0, -1, 1'b0, 0);

        // Narrow counters, buffer model: every vector fails, count must not wrap.
        @(negedge clk) start_s = 1'b1;
        @(negedge clk) start_s = 1'b0;
        n = 0;
        while (!done_s && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("small_done", {31'd0, done_s}, 32'd1);
        check("small_err", {28'd0, err_s}, 32'd15);
        check("small_vec", {28'd0, vec_s}, 32'd15);
        check("small_pass", {31'd0, pass_s}, 32'd0);
        $display("[TB] run small: err=%0d vec=%0d pass=%0b", err_s, vec_s, pass_s);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
